key_color_ctrl: RTL

Sequencing controller for the piano's key-to-colour decoder. It synchronises and debounces the raw key inputs and arbitrates simultaneous presses. It enforces a minimum display time per note and can autonomously play a stored demo melody. It drives the 4-bit note code `p3..p0` consumed by `color`, which maps codes 1–9 to RGB; code 0 is dark. It sits between the keyboard pins and `color`, one instance per board.

---
 rtl/key_color_ctrl_pkg.sv | 28 ++
 rtl/key_color_ctrl_if.sv | 25 ++
 rtl/key_color_ctrl_debounce.sv | 54 +++++
 rtl/key_color_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/key_color_ctrl_pkg.sv
// Shared types and constants for the piano key-to-colour sequencer.
// Holds the controller state encoding, note code type, demo melody and arbitration helper.
package piano_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, HOLD, DEMO} ctrl_state_t;

   typedef logic [3:0] note_code_t;

   localparam note_code_t CODE_OFF   = 4'd0;
   localparam int         NUM_KEYS   = 8;
   localparam int         MELODY_LEN = 16;

   localparam note_code_t MELODY [MELODY_LEN] = '{
      4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6, 4'd5, 4'd0,
      4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0
   };

   // Lowest-index set key wins; returns its code (index+1), or CODE_OFF when none is set.
   function automatic note_code_t winner_code(input logic [NUM_KEYS-1:0] v);
      winner_code = CODE_OFF;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i]) begin
            winner_code = note_code_t'(i + 1);
         end
      end
   endfunction

endpackage

// File: rtl/key_color_ctrl_if.sv
// Pin-level bundle between the keyboard/demo inputs, the controller and the colour decoder.
// The slave modport is the controller's view; master is the driver side.
interface key_color_ctrl_if;
   import piano_pkg::*;

   logic [NUM_KEYS-1:0] key;
   logic                demo;
   logic                p0;
   logic                p1;
   logic                p2;
   logic                p3;
   logic                note_valid;
   logic                demo_active;

   modport master (
      output key, demo,
      input  p0, p1, p2, p3, note_valid, demo_active
   );

   modport slave (
      input  key, demo,
      output p0, p1, p2, p3, note_valid, demo_active
   );

endinterface

// File: rtl/key_color_ctrl_debounce.sv
// Two-flop synchroniser and debounce filter for the raw key vector.
// stable follows the synchronised keys once they have held still long enough.
module key_debounce
   import piano_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_i,
   output logic [NUM_KEYS-1:0] stable_o
);

   localparam logic [15:0] DEB_LIM = 16'(DEB_CYCLES);

   logic [NUM_KEYS-1:0] meta_q;
   logic [NUM_KEYS-1:0] sync_q;
   logic [NUM_KEYS-1:0] prev_q;
   logic [NUM_KEYS-1:0] stable_q, stable_d;
   logic [15:0]         cnt_q, cnt_d;

   // Any change restarts the run; the counter parks at the limit so stable keeps tracking.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync_q != prev_q) begin
         cnt_d = '0;
      end else if (cnt_q != DEB_LIM) begin
         cnt_d = cnt_q + 16'd1;
      end
      if ((sync_q == prev_q) && (cnt_d == DEB_LIM)) begin
         stable_d = sync_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= '0;
         sync_q   <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         meta_q   <= key_i;
         sync_q   <= meta_q;
         prev_q   <= sync_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/key_color_ctrl.sv
// Key/demo sequencing controller driving the 4-bit note code into the colour decoder.
// Arbitrates debounced keys, enforces a minimum note time and plays the stored melody.
module key_color_ctrl
   import piano_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = 16,
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter int unsigned STEP_CYCLES = 4000
) (
   input  logic          clk,
   input  logic          rst_n,
   key_color_ctrl_if.slave bus
);

   localparam logic [15:0] HOLD_LIM = 16'(HOLD_CYCLES);
   localparam logic [15:0] STEP_LIM = 16'(STEP_CYCLES);
   localparam logic [3:0]  LAST_IDX = 4'(MELODY_LEN - 1);

   logic [NUM_KEYS-1:0] stable;
   logic                any_key;
   note_code_t          win_code;

   logic                demo_meta_q, demo_sync_q, demo_prev_q;
   logic                demo_rise;

   ctrl_state_t         state_q, state_d;
   note_code_t          code_q, code_d;
   logic [15:0]         hold_q, hold_d, hold_next;
   logic [15:0]         step_q, step_d, step_next;
   logic [3:0]          idx_q, idx_d, idx_inc;
   logic                hold_done, step_done;
   logic                valid_q, valid_d;
   logic                active_q, active_d;

   key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_i    (bus.key),
      .stable_o (stable)
   );

   assign any_key   = |stable;
   assign win_code  = winner_code(stable);
   assign demo_rise = demo_sync_q & ~demo_prev_q;

   // hold_done means the current code will have been shown for HOLD_CYCLES after this edge.
   assign hold_next = (hold_q == HOLD_LIM) ? hold_q : hold_q + 16'd1;
   assign hold_done = (hold_next == HOLD_LIM);
   assign step_next = step_q + 16'd1;
   assign step_done = (step_next == STEP_LIM);
   assign idx_inc   = idx_q + 4'd1;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      hold_d  = hold_q;
      step_d  = step_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            code_d = CODE_OFF;
            if (any_key) begin
               state_d = PLAY;
               code_d  = win_code;
               hold_d  = '0;
            end else if (demo_rise) begin
               state_d = DEMO;
               idx_d   = '0;
               step_d  = '0;
               code_d  = MELODY[0];
            end
         end
         PLAY: begin
            hold_d = hold_next;
            if (any_key) begin
               if (hold_done && (win_code != code_q)) begin
                  code_d = win_code;
                  hold_d = '0;
               end
            end else if (hold_done) begin
               state_d = IDLE;
               code_d  = CODE_OFF;
            end else begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            hold_d = hold_next;
            if (any_key && (win_code == code_q)) begin
               state_d = PLAY;
            end else if (hold_done) begin
               if (any_key) begin
                  state_d = PLAY;
                  code_d  = win_code;
                  hold_d  = '0;
               end else begin
                  state_d = IDLE;
                  code_d  = CODE_OFF;
               end
            end
         end
         DEMO: begin
            if (any_key) begin
               state_d = PLAY;
               code_d  = win_code;
               hold_d  = '0;
            end else if (step_done) begin
               step_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  code_d  = CODE_OFF;
                  idx_d   = '0;
               end else begin
                  idx_d  = idx_inc;
                  code_d = MELODY[idx_inc];
               end
            end else begin
               step_d = step_next;
            end
         end
         default: begin
            state_d = IDLE;
            code_d  = CODE_OFF;
         end
      endcase
      valid_d  = (code_d != CODE_OFF);
      active_d = (state_d == DEMO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         demo_meta_q <= 1'b0;
         demo_sync_q <= 1'b0;
         demo_prev_q <= 1'b0;
         state_q     <= IDLE;
         code_q      <= CODE_OFF;
         hold_q      <= '0;
         step_q      <= '0;
         idx_q       <= '0;
         valid_q     <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         demo_meta_q <= bus.demo;
         demo_sync_q <= demo_meta_q;
         demo_prev_q <= demo_sync_q;
         state_q     <= state_d;
         code_q      <= code_d;
         hold_q      <= hold_d;
         step_q      <= step_d;
         idx_q       <= idx_d;
         valid_q     <= valid_d;
         active_q    <= active_d;
      end
   end

   assign bus.p0          = code_q[0];
   assign bus.p1          = code_q[1];
   assign bus.p2          = code_q[2];
   assign bus.p3          = code_q[3];
   assign bus.note_valid  = valid_q;
   assign bus.demo_active = active_q;

endmodule
